// File: rtl/collision_monitor.sv
// Sprite-footprint collision monitor: counts hazard-coloured samples per scan, latches a sticky hit and edge flags.
// Optional COLLISION_DEBOUNCE_EN requires two consecutive hit scans before collided sets.
module collision_monitor #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         MARGIN       = 3,
  parameter logic [2:0] HAZ_COLOUR_A = 3'b010,
  parameter logic [2:0] HAZ_COLOUR_B = 3'b100,
  parameter int         HIT_THRESH   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       sample_valid,
  input  logic [7:0] x_coord,
  input  logic [6:0] y_coord,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       collided,
  output logic       hit_pulse,
  output logic [3:0] edge_flags,
  output logic       reached_screen_end,
  output logic [7:0] hit_count
);

  localparam logic [7:0] X_RIGHT  = 8'(SCREEN_W - 1 - MARGIN);
  localparam logic [7:0] X_LEFT   = 8'(MARGIN);
  localparam logic [6:0] Y_BOTTOM = 7'(SCREEN_H - 1 - MARGIN);
  localparam logic [6:0] Y_TOP    = 7'(MARGIN);
  localparam logic [7:0] THRESH   = 8'(HIT_THRESH);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, LATCHED} state_t;

  state_t     state, state_nxt;
  logic [7:0] counter;
  logic       is_haz, start_scan, restart, count_en, do_eval;
  logic       hit_frame, qualify;
  logic [3:0] edge_set;

  assign is_haz    = sample_valid && (colour == HAZ_COLOUR_A || colour == HAZ_COLOUR_B);
  assign hit_frame = (counter >= THRESH);
  assign restart   = (state == SCAN) && frame_start;
  assign edge_set  = {4{sample_valid}} & {(y_coord <= Y_TOP), (y_coord >= Y_BOTTOM),
                                          (x_coord <= X_LEFT), (x_coord >= X_RIGHT)};

`ifdef COLLISION_DEBOUNCE_EN
  // Remembers whether the previous evaluated scan was a hit frame.
  logic hit_hist;

  assign qualify = hit_frame && hit_hist;

  always_ff @(posedge clock) begin
    if (!resetn || clear)
      hit_hist <= 1'b0;
    else if (restart)
      hit_hist <= 1'b0;
    else if (do_eval)
      hit_hist <= hit_frame;
  end
`else
  assign qualify = hit_frame;
`endif

  always_ff @(posedge clock) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_scan = 1'b0;
    count_en   = 1'b0;
    do_eval    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_scan = 1'b1;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (frame_start) begin
          start_scan = 1'b1;
        end else begin
          count_en = 1'b1;
          if (frame_end)
            state_nxt = EVAL;
        end
      end
      EVAL: begin
        do_eval   = 1'b1;
        state_nxt = qualify ? LATCHED : IDLE;
      end
      LATCHED: state_nxt = LATCHED;
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
      do_eval   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      collided   <= 1'b0;
      hit_pulse  <= 1'b0;
      edge_flags <= 4'b0;
      hit_count  <= 8'd0;
      counter    <= 8'd0;
    end else if (clear) begin
      collided   <= 1'b0;
      hit_pulse  <= 1'b0;
      edge_flags <= 4'b0;
      counter    <= 8'd0;
    end else begin
      hit_pulse  <= 1'b0;
      edge_flags <= edge_flags | edge_set;
      // A new or restarted scan counts a coincident hazard sample as its first.
      if (start_scan)
        counter <= {7'd0, is_haz};
      else if (count_en && is_haz && counter != 8'hFF)
        counter <= counter + 8'd1;
      if (do_eval) begin
        hit_count <= counter;
        if (qualify) begin
          collided  <= 1'b1;
          hit_pulse <= 1'b1;
        end
      end
    end
  end

  assign reached_screen_end = edge_flags[0];

endmodule
